tm1638_driver: RTL and testbench

//  Autonomous refresh engine for the TM1638 display/key board on the iCE40 SoC.

---
 rtl/tm1638_pkg.sv | 18 +
 rtl/tm1638_if.sv | 13 +
 rtl/tm1638_byte_phy.sv | 66 ++++++
 rtl/tm1638_driver.sv | 122 ++++++++++++
 tb/tb_tm1638_driver.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/tm1638_pkg.sv
// tm1638_pkg: TM1638 command bytes and FSM encodings shared by the driver and its byte PHY
package tm1638_pkg;

    localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR0      = 8'hC0;
    localparam logic [7:0] CMD_DISP_ON    = 8'h88;
    localparam logic [7:0] CMD_DISP_OFF   = 8'h80;
    localparam logic [7:0] CMD_READ_KEYS  = 8'h42;

    typedef enum logic [2:0] {S_GAP, S_SETUP, S_BYTES, S_READ_WAIT, S_RBYTES, S_HOLD, S_IDLE} state_t;
    typedef enum logic [1:0] {F_WRITE, F_DATA, F_DISP, F_READ} frame_t;
    typedef enum logic [1:0] {PHY_IDLE, BIT_LOW, BIT_HIGH} phy_state_t;

    function automatic logic [7:0] disp_cmd(input logic on, input logic [2:0] level);
        return on ? (CMD_DISP_ON | {5'b0, level}) : CMD_DISP_OFF;
    endfunction

endpackage

// File: rtl/tm1638_if.sv
// tm1638_if: register-side bus between the io block (master) and the TM1638 driver (slave)
interface tm1638_if;
    logic [63:0] segments;
    logic [7:0]  leds;
    logic [2:0]  brightness;
    logic        display_on;
    logic [7:0]  keys;
    logic        keys_valid;
    logic        busy;

    modport master (output segments, leds, brightness, display_on, input keys, keys_valid, busy);
    modport slave (input segments, leds, brightness, display_on, output keys, keys_valid, busy);
endinterface

// File: rtl/tm1638_byte_phy.sv
// tm1638_byte_phy: shifts one byte LSB first out on DIO or in from DIO with TM1638 CLK timing
module tm1638_byte_phy
    import tm1638_pkg::*;
#(
    parameter int HALF_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       rd,
    input  logic [7:0] wdata,
    input  logic       dio_in,
    output logic       done,
    output logic [7:0] rdata,
    output logic       clk_out,
    output logic       dio_out,
    output logic       dio_oe
);
    localparam int HW = $clog2(HALF_CYCLES + 1);
    localparam logic [HW-1:0] HALF_LOAD = HW'(HALF_CYCLES - 1);

    phy_state_t st;
    logic [HW-1:0] tmr;
    logic [2:0] bitn;
    logic [7:0] sr;

    assign done = (st == BIT_HIGH) && (tmr == '0) && (bitn == 3'd7);
    assign rdata = sr;

    // bit sequencer: a start during the final high phase chains the next byte with no idle cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            st <= PHY_IDLE;
            tmr <= '0;
            bitn <= '0;
            sr <= '0;
            clk_out <= 1'b1;
            dio_out <= 1'b1;
            dio_oe <= 1'b0;
        end else if (start && (st == PHY_IDLE || done)) begin
            st <= BIT_LOW;
            tmr <= HALF_LOAD;
            bitn <= '0;
            sr <= wdata;
            clk_out <= 1'b0;
            dio_out <= wdata[0];
            dio_oe <= !rd;
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end else if (st == BIT_LOW) begin
            st <= BIT_HIGH;
            tmr <= HALF_LOAD;
            clk_out <= 1'b1;
            sr <= {dio_in, sr[7:1]};
        end else if (done) begin
            st <= PHY_IDLE;
            dio_oe <= 1'b0;
        end else if (st == BIT_HIGH) begin
            st <= BIT_LOW;
            tmr <= HALF_LOAD;
            bitn <= bitn + 3'd1;
            clk_out <= 1'b0;
            dio_out <= sr[0];
        end
    end
endmodule

// File: rtl/tm1638_driver.sv
// tm1638_driver: autonomous TM1638 refresh engine (display write frames plus key scan readback)
module tm1638_driver
    import tm1638_pkg::*;
#(
    parameter int HALF_CYCLES    = 3,
    parameter int GAP_CYCLES     = 12,
    parameter int TWAIT_CYCLES   = 12,
    parameter int REFRESH_CYCLES = 60000
) (
    input  logic      clock,
    input  logic      reset,
    tm1638_if.slave   bus,
    output logic      tm_strobe,
    output logic      tm_clock,
    inout  wire       tm_dio
);
    localparam int TW = $clog2(REFRESH_CYCLES);

    state_t state;
    frame_t frame;
    logic [4:0] idx;
    logic [TW-1:0] tmr;
    logic wrapped;
    logic [63:0] seg_q;
    logic [7:0] led_q, disp_q, acc, wdata, rdata;
    logic [1:0] k;
    logic start, start_w, start_r, last_w, done, dio_out, dio_oe;

    assign tm_dio = dio_oe ? dio_out : 1'bz;

    // next byte to send, keyed by frame and the count of bytes already started
    always_comb begin
        wdata = frame == F_WRITE ? CMD_WRITE_AUTO :
                frame == F_DISP  ? disp_q :
                frame == F_READ  ? CMD_READ_KEYS :
                idx == 5'd0      ? CMD_ADDR0 :
                idx[0]           ? seg_q[{idx[3:1], 3'b000} +: 8] :
                                   {7'b0, led_q[3'(idx[4:1] - 4'd1)]};
        last_w = (frame == F_DATA) ? (idx == 5'd17) : 1'b1;
        start_w = (state == S_SETUP && tmr == '0) || (state == S_BYTES && done && !last_w);
        start_r = (state == S_READ_WAIT && tmr == '0) || (state == S_RBYTES && done && idx != 5'd4);
        start = start_w || start_r;
        k = idx[1:0] - 2'd1;
    end

    tm1638_byte_phy #(.HALF_CYCLES(HALF_CYCLES)) phy (
        .clock(clock), .reset(reset), .start(start), .rd(start_r), .wdata(wdata),
        .dio_in(tm_dio), .done(done), .rdata(rdata), .clk_out(tm_clock),
        .dio_out(dio_out), .dio_oe(dio_oe)
    );

    // frame sequencer: strobe framing, input snapshot at F0, key decode at the F3 strobe rise
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_GAP;
            frame <= F_WRITE;
            idx <= '0;
            tmr <= TW'(GAP_CYCLES - 1);
            wrapped <= 1'b0;
            tm_strobe <= 1'b1;
            seg_q <= '0;
            led_q <= '0;
            disp_q <= CMD_DISP_OFF;
            acc <= '0;
            bus.keys <= '0;
            bus.keys_valid <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            bus.keys_valid <= 1'b0;
            if (start) idx <= idx + 5'd1;
            if (tmr != '0) tmr <= tmr - 1'b1;
            case (state)
                S_GAP, S_IDLE: if (tmr == '0) begin
                    if (state == S_GAP && wrapped) begin
                        state <= S_IDLE;
                        tmr <= TW'(REFRESH_CYCLES - 1);
                        wrapped <= 1'b0;
                        bus.busy <= 1'b0;
                    end else begin
                        state <= S_SETUP;
                        tmr <= TW'(HALF_CYCLES - 1);
                        idx <= '0;
                        tm_strobe <= 1'b0;
                        bus.busy <= 1'b1;
                        if (frame == F_WRITE) begin
                            seg_q <= bus.segments;
                            led_q <= bus.leds;
                            disp_q <= disp_cmd(bus.display_on, bus.brightness);
                        end
                    end
                end
                S_SETUP: if (tmr == '0) state <= S_BYTES;
                S_BYTES: if (done && last_w) begin
                    state <= frame == F_READ ? S_READ_WAIT : S_HOLD;
                    tmr <= frame == F_READ ? TW'(TWAIT_CYCLES - 1) : TW'(HALF_CYCLES - 1);
                    idx <= '0;
                end
                S_READ_WAIT: if (tmr == '0) state <= S_RBYTES;
                S_RBYTES: if (done) begin
                    acc[{1'b0, k}] <= rdata[0];
                    acc[{1'b1, k}] <= rdata[4];
                    if (idx == 5'd4) begin
                        state <= S_HOLD;
                        tmr <= TW'(HALF_CYCLES - 1);
                    end
                end
                S_HOLD: if (tmr == '0) begin
                    state <= S_GAP;
                    tmr <= TW'(GAP_CYCLES - 1);
                    tm_strobe <= 1'b1;
                    frame <= frame_t'(frame + 2'd1);
                    if (frame == F_READ) begin
                        bus.keys <= acc;
                        bus.keys_valid <= 1'b1;
                        wrapped <= 1'b1;
                    end
                end
                default: state <= S_GAP;
            endcase
        end
    end
endmodule

// File: tb/tb_tm1638_driver.sv
// tb_tm1638_driver: table-driven check of TM1638 frames against a bench-side TM1638 model
module tb_tm1638_driver;
    logic clock = 1'b0;
    logic reset = 1'b1;
    wire tm_dio;
    logic tm_strobe, tm_clock;
    logic tb_oe = 1'b0;
    logic tb_val = 1'b1;
    int errors = 0;
    int checks = 0;

    tm1638_if bus ();

    tm1638_driver #(.HALF_CYCLES(3), .GAP_CYCLES(12), .TWAIT_CYCLES(12), .REFRESH_CYCLES(200)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .tm_strobe(tm_strobe), .tm_clock(tm_clock), .tm_dio(tm_dio)
    );

    assign tm_dio = tb_oe ? tb_val : 1'bz;

    always #5 clock = ~clock;

    // model state and frame log, written only by the monitor
    logic [7:0] fb [32][17];
    int fcnt [32];
    int flen [32];
    int fgap [32];
    logic kv_rise [32];
    logic [7:0] k_rise [32];
    int nf = 0, lowcnt = 0, hicnt = 0, nbits = 0, nbytes = 0, rd_bad = 0, kv_total = 0;
    logic [5:0] rbit = '0;
    logic [7:0] sh = '0;
    logic rd_mode = 1'b0, stb_p = 1'b1, clk_p = 1'b1;
    logic [31:0] resp = 32'h0000_1001;

    // TM1638 model: logs written bytes per frame, answers key reads after a 0x42 command
    always @(negedge clock) begin
        if (stb_p && !tm_strobe) begin
            if (nf < 32) fgap[nf] = hicnt;
            lowcnt = 0;
            nbits = 0;
            nbytes = 0;
            rd_mode = 1'b0;
        end
        if (!stb_p && tm_strobe) begin
            tb_oe = 1'b0;
            if (nf < 32) begin
                fcnt[nf] = nbytes;
                flen[nf] = lowcnt;
                kv_rise[nf] = bus.keys_valid;
                k_rise[nf] = bus.keys;
            end
            nf++;
            hicnt = 0;
        end
        if (!tm_strobe && !clk_p && tm_clock) begin
            if (rd_mode) begin
                if (tm_dio !== tb_val || dut.dio_oe) rd_bad++;
                rbit = rbit + 6'd1;
            end else begin
                sh = {tm_dio, sh[7:1]};
                nbits++;
                if (nbits == 8) begin
                    if (nf < 32 && nbytes < 17) fb[nf][nbytes] = sh;
                    if (nbytes == 0 && sh == 8'h42) begin
                        rd_mode = 1'b1;
                        rbit = '0;
                    end
                    nbytes++;
                    nbits = 0;
                end
            end
        end
        if (!tm_strobe && clk_p && !tm_clock && rd_mode) begin
            tb_oe = 1'b1;
            tb_val = rbit[5] ? 1'b1 : resp[rbit[4:0]];
        end
        if (bus.keys_valid) kv_total++;
        if (!tm_strobe) lowcnt++; else hicnt++;
        stb_p = tm_strobe;
        clk_p = tm_clock;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_nf(input int n, input int budget);
        int c = 0;
        while (nf < n && c < budget) begin
            @(posedge clock);
            #2;
            c++;
        end
        chk($sformatf("frames_reach_%0d", n), nf >= n, 1);
    endtask

    task automatic wait_low(input int budget);
        int c = 0;
        while (tm_strobe && c < budget) begin
            @(posedge clock);
            #1;
            c++;
        end
        chk("strobe_fall_wait", tm_strobe, 0);
    endtask

    task automatic count_fall(input string nm);
        int n = 0;
        while (tm_strobe && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(nm, n, 12);
    endtask

    typedef struct {
        int f;
        int i;
        int exp;
    } vec_t;
    vec_t v [$];

    function automatic void add(input int f, input int i, input int exp);
        vec_t e;
        e.f = f;
        e.i = i;
        e.exp = exp;
        v.push_back(e);
    endfunction

    task automatic run_table();
        foreach (v[n]) chk($sformatf("frame%0d_byte%0d", v[n].f, v[n].i), fb[v[n].f][v[n].i], v[n].exp);
        v.delete();
    endtask

    initial begin
        int old_f1 [17] = '{8'hC0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h02, 8'h01, 8'h03, 8'h00,
                            8'h04, 8'h00, 8'h05, 8'h01, 8'h06, 8'h00, 8'h07, 8'h01};
        int new_f1 [17] = '{8'hC0, 8'h88, 8'h01, 8'h77, 8'h01, 8'h66, 8'h01, 8'h55, 8'h01,
                            8'h44, 8'h00, 8'h33, 8'h00, 8'h22, 8'h00, 8'h11, 8'h00};
        bus.segments = 64'h0706050403020100;
        bus.leds = 8'hA5;
        bus.brightness = 3'd5;
        bus.display_on = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        chk("rst_strobe", tm_strobe, 1);
        chk("rst_clock", tm_clock, 1);
        chk("rst_dio_oe", dut.dio_oe, 0);
        chk("rst_keys", bus.keys, 0);
        chk("rst_keys_valid", bus.keys_valid, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge clock);
        reset = 1'b0;
        count_fall("first_fall_delay");
        #1;
        chk("busy_in_frame", bus.busy, 1);

        wait_nf(4, 3000);
        add(0, 0, 8'h40);
        for (int i = 0; i < 17; i++) add(1, i, old_f1[i]);
        add(2, 0, 8'h8D);
        add(3, 0, 8'h42);
        run_table();
        chk("f0_len", flen[0], 54);
        chk("f1_len", flen[1], 3 + 17 * 48 + 3);
        chk("f1_count", fcnt[1], 17);
        chk("f2_len", flen[2], 54);
        chk("f3_len", flen[3], 3 + 48 + 12 + 4 * 48 + 3);
        chk("gap_f0_f1", fgap[1], 12);
        chk("keys_valid_at_rise", kv_rise[3], 1);
        chk("keys_at_rise", k_rise[3], 8'h21);
        chk("busy_in_gap", bus.busy, 1);
        repeat (20) @(posedge clock);
        #1;
        chk("busy_idle", bus.busy, 0);
        chk("strobe_idle", tm_strobe, 1);

        wait_nf(5, 2000);
        wait_low(100);
        repeat (100) @(posedge clock);
        bus.segments = 64'h1122334455667788;
        bus.leds = 8'h0F;
        bus.display_on = 1'b0;
        wait_nf(12, 6000);
        add(5, 1, 8'h00);
        add(5, 2, 8'h01);
        add(5, 15, 8'h07);
        add(5, 16, 8'h01);
        add(6, 0, 8'h8D);
        add(7, 0, 8'h42);
        for (int i = 0; i < 17; i++) add(9, i, new_f1[i]);
        add(10, 0, 8'h80);
        run_table();
        chk("refresh_gap", fgap[4], 12 + 200);
        chk("keys_refresh3", k_rise[11], 8'h21);
        chk("keys_valid_pulses", kv_total, 3);
        chk("read_dio_contention", rd_bad, 0);

        wait_nf(13, 2000);
        wait_low(100);
        repeat (50) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_strobe", tm_strobe, 1);
        chk("abort_clock", tm_clock, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_keys", bus.keys, 0);
        chk("abort_dio_oe", dut.dio_oe, 0);
        @(negedge clock);
        reset = 1'b0;
        count_fall("restart_fall_delay");
        wait_nf(15, 500);
        add(14, 0, 8'h40);
        run_table();
        chk("restart_f0_len", flen[14], 54);
        chk("restart_f0_count", fcnt[14], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
